// File: rtl/pill_taken_recorder.sv
// Debounces the three pill "taken" buttons and classifies each press as a valid dose or an early attempt.
// Also tracks saturating per-pill taken counts and sticky missed-dose flags.
module pill_taken_recorder #(
   parameter int         DEBOUNCE_CYCLES = 16,
   parameter logic [3:0] MONITOR_STATE   = 4'd3,
   parameter logic [3:0] CLEAR_STATE     = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  state,
   input  logic [2:0]  pillButton,
   input  logic [11:0] pill12And3Duration,
   input  logic        clearFlags,
   output logic [2:0]  signalFromPillTakenRecorder,
   output logic [2:0]  earlyAttempt,
   output logic [2:0]  missedDose,
   output logic [11:0] pill12And3TakenCount
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {RELEASED, ARMED, HELD} chan_state_t;

   chan_state_t [2:0]   cs;
   chan_state_t [2:0]   ns;
   logic [2:0][CW-1:0]  cnt;
   logic [2:0]          deb;
   logic [2:0]          commit;
   logic [2:0]          rise;
   logic [2:0]          fall;
   logic [2:0]          armed;
   logic [2:0]          due;
   logic [2:0]          take;
   logic [2:0]          early_set;
   logic [2:0]          miss_set;
   logic [2:0]          zero_prev;
   logic [2:0]          pulse;
   logic [2:0]          pulse_prev;
   logic [2:0]          early;
   logic [2:0]          missed;
   logic [11:0]         count;
   logic                monitoring;

   assign monitoring = (state == MONITOR_STATE);

   // commit is the cycle on which the debounced level will follow the raw level
   always_comb begin
      commit = '0;
      rise   = '0;
      fall   = '0;
      due    = '0;
      for (int i = 0; i < 3; i++) begin
         commit[i] = (pillButton[i] != deb[i]) && (cnt[i] == CNT_LAST);
         rise[i]   = commit[i] & pillButton[i];
         fall[i]   = commit[i] & ~pillButton[i];
         due[i]    = (pill12And3Duration[(2-i)*4 +: 4] == 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb <= '0;
         cnt <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (pillButton[i] != deb[i]) begin
               if (commit[i]) begin
                  deb[i] <= pillButton[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cs <= {RELEASED, RELEASED, RELEASED};
      end else begin
         cs <= ns;
      end
   end

   // ARMED is entered on the same edge the debounced level rises, so it is evaluated one cycle later
   always_comb begin
      ns = cs;
      for (int i = 0; i < 3; i++) begin
         case (cs[i])
            RELEASED: if (rise[i]) ns[i] = ARMED;
            ARMED:    ns[i] = fall[i] ? RELEASED : HELD;
            HELD:     if (fall[i]) ns[i] = RELEASED;
            default:  ns[i] = RELEASED;
         endcase
      end
   end

   always_comb begin
      armed = '0;
      for (int i = 0; i < 3; i++) begin
         armed[i] = (cs[i] == ARMED);
      end
   end

   assign take      = armed & {3{monitoring}} & due;
   assign early_set = armed & {3{monitoring}} & ~due;
   // a reload right after our own pulse is the monitor accepting the dose, not a miss
   assign miss_set  = {3{monitoring}} & zero_prev & ~due & ~pulse_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         pulse      <= '0;
         pulse_prev <= '0;
         zero_prev  <= '0;
         early      <= '0;
         missed     <= '0;
         count      <= '0;
      end else begin
         pulse      <= take;
         pulse_prev <= pulse;
         zero_prev  <= due;
         early      <= (early  & ~{3{clearFlags}}) | early_set;
         missed     <= (missed & ~{3{clearFlags}}) | miss_set;
         for (int i = 0; i < 3; i++) begin
            if (state == CLEAR_STATE) begin
               count[(2-i)*4 +: 4] <= 4'd0;
            end else if (take[i] && (count[(2-i)*4 +: 4] != 4'hF)) begin
               count[(2-i)*4 +: 4] <= count[(2-i)*4 +: 4] + 4'd1;
            end
         end
      end
   end

   assign signalFromPillTakenRecorder = pulse;
   assign earlyAttempt                = early;
   assign missedDose                  = missed;
   assign pill12And3TakenCount        = count;

endmodule

// File: doc/pill_taken_recorder.md
Name: pill_taken_recorder

Overview:
- Upstream stage of the next-pill monitor. Debounces the three pill-compartment "taken" buttons and decides whether each press is a valid dose.
- A valid dose is a press while the monitor is running (state 3) and that pill's remaining duration is 0. Each valid dose produces a one-cycle taken pulse, which drives the monitor's signalFromPillTakenRecorder input.
- Also keeps per-pill taken counts and sticky early-attempt and missed-dose flags for the display/alarm logic.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles of changed raw level required before the debounced level follows it (min 2).
- MONITOR_STATE, 4'd3: state code in which presses are evaluated and misses are detected.
- CLEAR_STATE, 4'd0: state code in which the taken counts are cleared.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- state  in  4  control FSM state
- pillButton  in  3  raw buttons, already synchronous to clk; bit0=pill1, bit1=pill2, bit2=pill3
- pill12And3Duration  in  12  hours remaining from the monitor; [11:8]=pill1, [7:4]=pill2, [3:0]=pill3
- clearFlags  in  1  one-cycle clear of earlyAttempt and missedDose
- signalFromPillTakenRecorder  out  3  one-cycle taken pulse per pill
- earlyAttempt  out  3  sticky: pressed while the pill was not due
- missedDose  out  3  sticky: the pill's due window expired without being taken
- pill12And3TakenCount  out  12  saturating 4-bit taken counts, same nibble order as the duration input

Behaviour:
- Reset, checked every edge and overriding everything: all outputs 0, debounced levels 0, debounce counters 0, internal history registers 0.
- Debounce (per channel):
  - A counter increments while raw != debounced.
  - The counter clears to 0 on any cycle where raw == debounced.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level takes the raw value and the counter returns to 0.
  - Timing: raw held high from edge 1 → debounced high after edge DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no change.
- Per-channel FSM:
  - RELEASED: debounced 0.
  - ARMED: a debounced 0→1 edge was just seen; lasts exactly one cycle.
  - HELD: debounced 1, locked out.
  - HELD → RELEASED only on debounced 1→0. Holding the button never produces a second event.
- Evaluation, on the cycle the channel is in ARMED:
  - state == MONITOR_STATE and duration nibble == 0: on the next edge, the taken pulse bit goes high for exactly one cycle, and that pill's count increments (saturates at 15).
  - state == MONITOR_STATE and nibble != 0: on the next edge, earlyAttempt bit is set; no pulse, no count change.
  - state != MONITOR_STATE: event discarded; the channel still proceeds to HELD.
- End-to-end latency: raw rise before edge 1 → pulse high after edge DEBOUNCE_CYCLES+1.
- Independence: channels are fully independent. Simultaneous presses on several pills yield simultaneous pulse bits in the same cycle.
- Miss detection, per channel, evaluated only while state == MONITOR_STATE:
  - Registered history: previous nibble == 0 (zeroPrev) and previous pulse bit (pulsePrev).
  - If zeroPrev == 1, current nibble != 0, and pulsePrev == 0, then missedDose bit is set on the next edge.
  - A reload caused by this block's own pulse (nibble returns nonzero the cycle after the pulse) must not set missedDose.
- Sticky flags:
  - Cleared only by clearFlags or reset.
  - If a set and clearFlags land in the same cycle, the set wins.
- Counts clear to 0 on any cycle with state == CLEAR_STATE.
- Button held through reset: after reset the debounced level is 0, so the held button re-debounces. After DEBOUNCE_CYCLES, an ARMED event occurs and is evaluated normally.
- Entering MONITOR_STATE with the button already held (channel in HELD): no event until the button is released and pressed again.
- State leaves MONITOR_STATE during a debounce: the debounce completes, and the resulting event is evaluated against the state at ARMED time.

Test Plan (DEBOUNCE_CYCLES=4):
- Press, pill due: state=3, duration=12'h000, pillButton=3'b001 held 10 cycles → signalFromPillTakenRecorder=3'b001 for exactly one cycle, 5 cycles after first high sample; count=12'h100; no further pulse while held.
- Early press: state=3, duration=12'h050, pillButton=3'b010 → no pulse; earlyAttempt=3'b010 stays set; one-cycle clearFlags → earlyAttempt=0.
- Glitch rejection: pillButton=3'b100 for 3 cycles, then 0; state=3, duration=0 → no pulse, no flags.
- Miss detection: state=3, pill1 nibble 0 for 20 cycles, then 4'h8 with no press → missedDose=3'b001. Repeat with a valid press before the reload → missedDose stays 0.
- Simultaneous presses: all three buttons pressed together, duration=0 → pulse=3'b111 in one cycle. After 16 more valid presses on each: counts=12'hFFF (saturated). Then state=0 for one cycle → counts=0.
- Reset mid-operation: pillButton=3'b001 held; reset asserted 1 cycle at debounce count 2 → outputs 0. Button still held, state=3, duration=0 → pulse 5 cycles after reset deasserts.
